// File: rtl/regfile_np.sv
// regfile_np: parametrised register file with NUM_RD combinational read
// ports, one synchronous write port, optional hardwired zero register and a
// hardware clear sweep after reset (one entry per cycle, Busy until done).
// Optional feature macro: REGFILE_BYPASS_EN (write-first bypass from the
// write port onto matching read ports while IDLE).
//
// Handshake: there is no valid/ready pair. RegWr is a one-cycle write
// request. It is accepted only when the FSM is IDLE and Reset is low.
// A request made while the block is sweeping is discarded and reported by a
// one-cycle WrDrop pulse on the following cycle. A request that coincides
// with a Reset edge is discarded silently, because reset clears WrDrop.
module regfile_np #(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 5,
    parameter int                 NUM_RD    = 2,
    parameter bit                 ZERO_REG  = 1'b1,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_RD*ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0]        RD,
    input  logic [DATA_W-1:0]        WData,
    input  logic                     RegWr,
    output logic [NUM_RD*DATA_W-1:0] RData,
    output logic                     Busy,
    output logic                     WrDrop
);

    localparam int DEPTH = 2**ADDR_W;

    // CLEAR: sweeping RESET_VAL into the array; IDLE: normal operation.
    // The state register is named 'state' so checkers can bind to it.
    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   ptr_nxt;
    logic                busy_nxt;
    logic                wrdrop_nxt;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_allowed;

    // A write to entry 0 is suppressed when entry 0 is the hardwired zero.
    assign wr_allowed = RegWr && !(ZERO_REG && (RD == '0));

    // Next-state, sweep pointer and write-port selection.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        busy_nxt   = Busy;
        wrdrop_nxt = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = RD;
        mem_wdata  = WData;
        case (state)
            CLEAR: begin
                // Sweep owns the write port; any requested write is dropped.
                mem_we     = 1'b1;
                mem_waddr  = ptr;
                mem_wdata  = RESET_VAL;
                ptr_nxt    = ptr + ADDR_W'(1);
                wrdrop_nxt = RegWr;
                if (ptr == {ADDR_W{1'b1}}) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            IDLE: begin
                mem_we = wr_allowed;
            end
            default: begin
                state_nxt = CLEAR;
                ptr_nxt   = '0;
                busy_nxt  = 1'b1;
            end
        endcase
        // Storage is left untouched on a reset edge.
        if (Reset) begin
            mem_we = 1'b0;
        end
    end

    // Control registers with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= CLEAR;
            ptr    <= '0;
            Busy   <= 1'b1;
            WrDrop <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            Busy   <= busy_nxt;
            WrDrop <= wrdrop_nxt;
        end
    end

    // Storage array: single write port, no reset (the sweep clears it).
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Independent combinational read ports.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] rs_i;
        logic [DATA_W-1:0] rdata_i;

        assign rs_i = RS[i*ADDR_W +: ADDR_W];

        // Priority, lowest to highest: array, bypass, sweep value, zero reg.
        always_comb begin
            rdata_i = mem[rs_i];
`ifdef REGFILE_BYPASS_EN
            if ((state == IDLE) && wr_allowed && (RD == rs_i)) begin
                rdata_i = WData;
            end
`endif
            if (Busy) begin
                rdata_i = RESET_VAL;
            end
            if (ZERO_REG && (rs_i == '0)) begin
                rdata_i = '0;
            end
        end

        assign RData[i*DATA_W +: DATA_W] = rdata_i;
    end

endmodule

// File: tb/tb_regfile_np.sv
// tb_regfile_np: directed bench for regfile_np. Three instances cover the
// default configuration, ZERO_REG=0 with a non-zero RESET_VAL (also used for
// the mid-sweep reset restart), and a 4-port 8x16 configuration.
module tb_regfile_np;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [31:0] RV_B = 32'hDEAD_BEEF;

    // ---------------- clock / reset ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for instances a and b.
    logic        rst_a, rst_b;
    logic [9:0]  rs;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        regwr;
    logic [63:0] rdata_a, rdata_b;
    logic        busy_a, busy_b, drop_a, drop_b;

    // Instance c stimulus.
    logic        rst_c;
    logic [11:0] rs_c;
    logic [2:0]  rd_c;
    logic [15:0] wdata_c;
    logic        regwr_c;
    logic [63:0] rdata_c;
    logic        busy_c, drop_c;

    regfile_np dut_a (
        .Clk(clk), .Reset(rst_a), .RS(rs), .RD(rd), .WData(wdata),
        .RegWr(regwr), .RData(rdata_a), .Busy(busy_a), .WrDrop(drop_a)
    );

    regfile_np #(.ZERO_REG(1'b0), .RESET_VAL(RV_B)) dut_b (
        .Clk(clk), .Reset(rst_b), .RS(rs), .RD(rd), .WData(wdata),
        .RegWr(regwr), .RData(rdata_b), .Busy(busy_b), .WrDrop(drop_b)
    );

    regfile_np #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut_c (
        .Clk(clk), .Reset(rst_c), .RS(rs_c), .RD(rd_c), .WData(wdata_c),
        .RegWr(regwr_c), .RData(rdata_c), .Busy(busy_c), .WrDrop(drop_c)
    );

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [31:0] ea0;
        logic [31:0] ea1;
        logic [31:0] eb0;
        logic [31:0] eb1;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [4:0] a, input logic [31:0] d,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] ea0, input logic [31:0] ea1,
                                input logic [31:0] eb0, input logic [31:0] eb1);
        vec_t v;
        v.wr = wr; v.rd = a; v.wd = d; v.rs0 = r0; v.rs1 = r1;
        v.ea0 = ea0; v.ea1 = ea1; v.eb0 = eb0; v.eb1 = eb1;
        return v;
    endfunction

    vec_t vt [10];

    initial begin
        int fall_a, fall_b, fall_c;

        // Vectors assume a is all-zero and b is all-DEADBEEF beforehand.
        vt[0] = mk(1, 5'd5,  32'h1234_5678, 0, 0, 0, 0, RV_B, RV_B);
        vt[1] = mk(1, 5'd31, 32'hFFFF_0000, 5, 6, 32'h1234_5678, 0, 32'h1234_5678, RV_B);
        vt[2] = mk(0, 5'd0,  32'h0, 5, 31, 32'h1234_5678, 32'hFFFF_0000,
                   32'h1234_5678, 32'hFFFF_0000);
        vt[3] = mk(1, 5'd0,  32'hAAAA_AAAA, 0, 0, 0, 0,
                   BYP ? 32'hAAAA_AAAA : RV_B, BYP ? 32'hAAAA_AAAA : RV_B);
        vt[4] = mk(0, 5'd0,  32'h0, 0, 0, 0, 0, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
        vt[5] = mk(1, 5'd9,  32'h1, 9, 9, BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0,
                   BYP ? 32'h1 : RV_B, BYP ? 32'h1 : RV_B);
        vt[6] = mk(1, 5'd9,  32'h2, 9, 9, BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1,
                   BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1);
        vt[7] = mk(0, 5'd0,  32'h0, 9, 9, 32'h2, 32'h2, 32'h2, 32'h2);
        vt[8] = mk(1, 5'd5,  32'hCAFE_F00D, 31, 5,
                   32'hFFFF_0000, BYP ? 32'hCAFE_F00D : 32'h1234_5678,
                   32'hFFFF_0000, BYP ? 32'hCAFE_F00D : 32'h1234_5678);
        vt[9] = mk(0, 5'd0,  32'h0, 5, 31, 32'hCAFE_F00D, 32'hFFFF_0000,
                   32'hCAFE_F00D, 32'hFFFF_0000);

        rst_a = 1; rst_b = 1; rst_c = 1;
        rs = {5'd5, 5'd0}; rd = 0; wdata = 0; regwr = 0;
        rs_c = 0; rd_c = 0; wdata_c = 0; regwr_c = 0;

        // ---- reset held 3 cycles ----
        repeat (3) tick();
        #1;
        chk("reset busy_a", 32'(busy_a), 32'h1);
        chk("reset drop_a", 32'(drop_a), 32'h0);
        chk("reset rdata_a p0 r0", rdata_a[31:0], 32'h0);
        chk("reset rdata_a p1 r5", rdata_a[63:32], 32'h0);
        chk("reset busy_b", 32'(busy_b), 32'h1);
        chk("reset rdata_b p0 r0", rdata_b[31:0], RV_B);
        chk("reset rdata_b p1 r5", rdata_b[63:32], RV_B);

        // ---- sweep: dropped write at edge 3, b restarted at edge 10 ----
        rst_a = 0; rst_b = 0;
        fall_a = 0; fall_b = 0;
        for (int n = 1; n <= 60; n++) begin
            regwr = (n == 3);
            rd    = 5'd7;
            wdata = 32'h55;
            rst_b = (n == 10);
            tick();
            if (n == 3) begin
                chk("wrdrop_a pulse", 32'(drop_a), 32'h1);
                chk("wrdrop_b pulse", 32'(drop_b), 32'h1);
            end
            if (n == 4) begin
                chk("wrdrop_a clears", 32'(drop_a), 32'h0);
                chk("wrdrop_b clears", 32'(drop_b), 32'h0);
            end
            if (n == 10) chk("restart busy_b", 32'(busy_b), 32'h1);
            if (!busy_a && fall_a == 0) fall_a = n;
            if (!busy_b && fall_b == 0 && n > 10) fall_b = n;
        end
        regwr = 0;
        chk("busy_a edges", 32'(fall_a), 32'd32);
        chk("busy_b edges after restart", 32'(fall_b - 10), 32'd32);

        // ---- every entry reads the sweep value (includes r7) ----
        for (int i = 0; i < 32; i++) begin
            rs = {5'(31 - i), 5'(i)};
            #1;
            chk("swept a p0", rdata_a[31:0], 32'h0);
            chk("swept a p1", rdata_a[63:32], 32'h0);
            chk("swept b p0", rdata_b[31:0], RV_B);
            chk("swept b p1", rdata_b[63:32], RV_B);
            tick();
        end
        chk("swept r7 drop_a idle", 32'(drop_a), 32'h0);

        // ---- table-driven IDLE vectors ----
        for (int k = 0; k < 10; k++) begin
            regwr = vt[k].wr; rd = vt[k].rd; wdata = vt[k].wd;
            rs = {vt[k].rs1, vt[k].rs0};
            #1;
            chk($sformatf("vec%0d a p0", k), rdata_a[31:0],  vt[k].ea0);
            chk($sformatf("vec%0d a p1", k), rdata_a[63:32], vt[k].ea1);
            chk($sformatf("vec%0d b p0", k), rdata_b[31:0],  vt[k].eb0);
            chk($sformatf("vec%0d b p1", k), rdata_b[63:32], vt[k].eb1);
            tick();
            chk($sformatf("vec%0d drop_a", k), 32'(drop_a), 32'h0);
            chk($sformatf("vec%0d drop_b", k), 32'(drop_b), 32'h0);
        end
        regwr = 0;

        // ---- 4-port 8x16 instance ----
        chk("c busy during reset", 32'(busy_c), 32'h1);
        chk("c drop during reset", 32'(drop_c), 32'h0);
        rst_c = 0;
        fall_c = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (!busy_c && fall_c == 0) fall_c = n;
        end
        chk("c busy edges", 32'(fall_c), 32'd8);

        for (int j = 1; j <= 6; j++) begin
            regwr_c = (j != 5);
            rd_c    = 3'(j);
            wdata_c = 16'(j * 16'h1111);
            tick();
        end
        regwr_c = 0;

        rs_c = {3'd4, 3'd3, 3'd2, 3'd1};
        #1;
        chk("c seq p0", 32'(rdata_c[15:0]),  32'h1111);
        chk("c seq p1", 32'(rdata_c[31:16]), 32'h2222);
        chk("c seq p2", 32'(rdata_c[47:32]), 32'h3333);
        chk("c seq p3", 32'(rdata_c[63:48]), 32'h4444);
        tick();
        rs_c = {3'd0, 3'd1, 3'd6, 3'd4};
        #1;
        chk("c perm p0", 32'(rdata_c[15:0]),  32'h4444);
        chk("c perm p1", 32'(rdata_c[31:16]), 32'h6666);
        chk("c perm p2", 32'(rdata_c[47:32]), 32'h1111);
        chk("c perm p3", 32'(rdata_c[63:48]), 32'h0);
        tick();
        rs_c = {3'd7, 3'd5, 3'd3, 3'd6};
        #1;
        chk("c unwritten p0", 32'(rdata_c[15:0]),  32'h6666);
        chk("c unwritten p1", 32'(rdata_c[31:16]), 32'h3333);
        chk("c unwritten p2", 32'(rdata_c[47:32]), 32'h0);
        chk("c unwritten p3", 32'(rdata_c[63:48]), 32'h0);

        // ---- final report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
